// File: rtl/switch_pkg.sv
// Shared sizing defaults, arbitration modes and destination-field extraction.
package switch_pkg;

   localparam int unsigned DEF_DATA_W = 10;
   localparam int unsigned DEF_N_IN   = 4;
   localparam int unsigned DEF_N_OUT  = 4;
   localparam int unsigned DEF_DEST_W = $clog2(DEF_N_OUT);

   localparam int unsigned MODE_RR    = 0;
   localparam int unsigned MODE_FIXED = 1;

   // Upper bounds for the width-generic destination helper.
   localparam int unsigned MAX_DATA_W = 64;
   localparam int unsigned MAX_DEST_W = 8;

   // Destination field is the dest_w MSBs of a data_w-wide word.
   function automatic logic [MAX_DEST_W-1:0] get_dest(input logic [MAX_DATA_W-1:0] word,
                                                      input int unsigned data_w,
                                                      input int unsigned dest_w);
      logic [MAX_DATA_W-1:0] sh;
      sh = (word >> (data_w - dest_w)) & ((MAX_DATA_W'(1) << dest_w) - MAX_DATA_W'(1));
      return MAX_DEST_W'(sh);
   endfunction

endpackage

// File: rtl/rr_route_switch_if.sv
// FIFO-bank side bundle of the router: input heads/pops, output fulls/pushes.
interface rr_route_switch_if
   import switch_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned N_IN   = DEF_N_IN,
   parameter int unsigned N_OUT  = DEF_N_OUT
);
   localparam int unsigned DEST_W = $clog2(N_OUT);

   logic [N_IN-1:0]         fifo_empty;
   logic [N_IN*DATA_W-1:0]  fifo_out;
   logic [N_IN-1:0]         fifo_pop;
   logic [N_OUT-1:0]        fifo_full;
   logic [N_OUT-1:0]        fifo_push;
   logic [N_OUT*DATA_W-1:0] fifo_in;
   logic [DEST_W-1:0]       dest;
   logic                    busy;

   modport master (
      output fifo_empty, fifo_out, fifo_full,
      input  fifo_pop, fifo_push, fifo_in, dest, busy
   );

   modport slave (
      input  fifo_empty, fifo_out, fifo_full,
      output fifo_pop, fifo_push, fifo_in, dest, busy
   );

endinterface

// File: rtl/rr_arbiter.sv
// N-way arbiter: round-robin from a rotating pointer, or fixed lowest-index priority.
module rr_arbiter
   import switch_pkg::*;
#(
   parameter int unsigned N    = DEF_N_IN,
   parameter int unsigned MODE = MODE_RR
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt,
   output logic         gnt_valid
);
   localparam int unsigned PTR_W = $clog2(N);

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] gnt_idx;
   logic [PTR_W-1:0] idx;
   int unsigned      sum;

   // Scan from the pointer (or from 0) and grant the first requester.
   always_comb begin
      gnt       = '0;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      idx       = '0;
      sum       = 0;
      for (int unsigned k = 0; k < N; k++) begin
         sum = (MODE == MODE_FIXED) ? k : 32'(ptr_q) + k;
         if (sum >= N) sum = sum - N;
         idx = PTR_W'(sum);
         if (!gnt_valid && req[idx]) begin
            gnt_valid = 1'b1;
            gnt[idx]  = 1'b1;
            gnt_idx   = idx;
         end
      end
   end

   // Pointer moves one past the winner; held when nothing is granted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q <= '0;
      end else if (gnt_valid) begin
         ptr_q <= (gnt_idx == PTR_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/rr_route_switch.sv
// N_IN x N_OUT word router: arbitrates deliverable input heads, pops one per
// cycle and pushes it into the destination output FIFO one cycle later.
module rr_route_switch
   import switch_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned N_IN   = DEF_N_IN,
   parameter int unsigned N_OUT  = DEF_N_OUT,
   parameter int unsigned MODE   = MODE_RR
) (
   input  logic            clk,
   input  logic            reset,
   rr_route_switch_if.slave sw
);
   localparam int unsigned DEST_W = $clog2(N_OUT);
   localparam int unsigned BUS_W  = N_OUT * DATA_W;

   logic [DATA_W-1:0] head_w [N_IN];
   logic [DEST_W-1:0] d_in   [N_IN];
   logic [N_IN-1:0]   elig;
   logic [N_IN-1:0]   gnt;
   logic              gnt_valid;
   logic [DATA_W-1:0] sel_word;
   logic [DEST_W-1:0] sel_dest;

   logic [N_OUT-1:0]  push_q;
   logic [BUS_W-1:0]  data_q;
   logic [DEST_W-1:0] dest_q;
   logic              busy_q;

   // An input is eligible when its head can land without overflowing or
   // colliding with the word already in the push stage; no requests in reset.
   always_comb begin
      elig = '0;
      for (int unsigned i = 0; i < N_IN; i++) begin
         head_w[i] = sw.fifo_out[i*DATA_W +: DATA_W];
         d_in[i]   = DEST_W'(get_dest(MAX_DATA_W'(head_w[i]), DATA_W, DEST_W));
         elig[i]   = reset && !sw.fifo_empty[i] && !sw.fifo_full[d_in[i]]
                     && !(busy_q && (dest_q == d_in[i]));
      end
   end

   rr_arbiter #(
      .N    (N_IN),
      .MODE (MODE)
   ) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (elig),
      .gnt       (gnt),
      .gnt_valid (gnt_valid)
   );

   // Select the granted head word and its destination.
   always_comb begin
      sel_word = '0;
      for (int unsigned i = 0; i < N_IN; i++) begin
         if (gnt[i]) sel_word = sel_word | head_w[i];
      end
      sel_dest = DEST_W'(get_dest(MAX_DATA_W'(sel_word), DATA_W, DEST_W));
   end

   // Push stage: capture the popped word and pre-decode the output slice.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         push_q <= '0;
         data_q <= '0;
         dest_q <= '0;
         busy_q <= 1'b0;
      end else begin
         busy_q <= gnt_valid;
         dest_q <= gnt_valid ? sel_dest : '0;
         push_q <= gnt_valid ? (N_OUT'(1) << sel_dest) : '0;
         data_q <= gnt_valid ? (BUS_W'(sel_word) << (32'(sel_dest) * DATA_W)) : '0;
      end
   end

   assign sw.fifo_pop  = gnt;
   assign sw.fifo_push = push_q;
   assign sw.fifo_in   = data_q;
   assign sw.dest      = dest_q;
   assign sw.busy      = busy_q;

endmodule
